johnson_monitor: RTL



---
 rtl/johnson_monitor_if.sv | 42 ++++
 rtl/johnson_monitor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/johnson_monitor_if.sv
// Bundle between an 8-bit Johnson counter and its checker.
//
// Signals:
//   count     counter value, driven by the upstream side
//   clr       synchronous status clear, driven by the upstream side
//   phase     decoded phase of the last sample
//   phase_vld last sample was a legal Johnson pattern
//   locked    checker FSM is in LOCK
//   err       sticky fault flag
//   err_cnt   saturating fault count
//   lap       one-cycle pulse on a completed 16-state lap while locked
//   lap_cnt   wrapping lap count
//   state     FSM state (0=UNLOCK 1=ACQ 2=LOCK 3=FAULT), debug visibility
//
// Handshake: there is no valid/ready. count and clr are sampled on every
// rising clock edge, and every output is refreshed on every edge. phase is
// meaningful only when phase_vld is 1; otherwise it holds its last legal value.
interface johnson_monitor_if #(
   parameter int ERR_W = 8,
   parameter int LAP_W = 8
);
   logic [7:0]       count;
   logic             clr;
   logic [3:0]       phase;
   logic             phase_vld;
   logic             locked;
   logic             err;
   logic [ERR_W-1:0] err_cnt;
   logic             lap;
   logic [LAP_W-1:0] lap_cnt;
   logic [1:0]       state;

   modport master (
      output count, clr,
      input  phase, phase_vld, locked, err, err_cnt, lap, lap_cnt, state
   );

   modport slave (
      input  count, clr,
      output phase, phase_vld, locked, err, err_cnt, lap, lap_cnt, state
   );
endinterface

// File: rtl/johnson_monitor.sv
// Checker for an 8-bit Johnson (twisted-ring) counter.
// Decodes every sample into a 4-bit phase, checks that each step is the legal
// Johnson successor, runs an UNLOCK/ACQ/LOCK/FAULT lock machine, keeps a
// sticky fault flag plus a saturating fault count, and counts full laps.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    johnson_monitor_if.slave (count/clr in, status out)
module johnson_monitor #(
   parameter int LOCK_N     = 4,
   parameter int ERR_W      = 8,
   parameter int LAP_W      = 8,
   parameter bit ALLOW_HOLD = 1'b0
) (
   input logic              clk,
   input logic              reset,
   johnson_monitor_if.slave bus
);

   typedef enum logic [1:0] {
      UNLOCK = 2'd0,
      ACQ    = 2'd1,
      LOCK   = 2'd2,
      FAULT  = 2'd3
   } state_t;

   localparam logic [3:0] LOCK_V = 4'(LOCK_N);

   state_t           state;
   logic [3:0]       good;
   logic [7:0]       prev;
   logic             first;
   logic [3:0]       phase_q;
   logic             phase_vld_q;
   logic             locked_q;
   logic             err_q;
   logic [ERR_W-1:0] err_cnt_q;
   logic             lap_q;
   logic [LAP_W-1:0] lap_cnt_q;

   // Legal pattern for phase p: p ones from the LSB for p<=8, then the
   // all-ones word with (p-8) zeros shifted in from the bottom.
   function automatic logic [7:0] pat(input int p);
      logic [15:0] t;
      if (p <= 8) t = (16'd1 << p) - 16'd1;
      else        t = 16'h00FF << (p - 8);
      return t[7:0];
   endfunction

   logic       legal;
   logic [3:0] dec;
   always_comb begin
      legal = 1'b0;
      dec   = 4'd0;
      for (int p = 0; p < 16; p++) begin
         if (bus.count == pat(p)) begin
            legal = 1'b1;
            dec   = p[3:0];
         end
      end
   end

   logic succ, hold_ok, adv, good_tr, lap_tr;
   logic [ERR_W-1:0] err_cnt_inc;
   always_comb begin
      succ        = (bus.count == {prev[6:0], ~prev[7]});
      hold_ok     = ALLOW_HOLD && (bus.count == prev);
      // adv: a step that moves the lock machine forward (holds do not)
      adv         = legal && (first || succ);
      good_tr     = adv || (legal && hold_ok);
      lap_tr      = (prev == 8'h80) && (bus.count == 8'h00);
      err_cnt_inc = (err_cnt_q == {ERR_W{1'b1}}) ? err_cnt_q
                                                 : err_cnt_q + ERR_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= UNLOCK;
         good        <= 4'd0;
         prev        <= 8'd0;
         first       <= 1'b1;
         phase_q     <= 4'd0;
         phase_vld_q <= 1'b0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
         lap_q       <= 1'b0;
         lap_cnt_q   <= '0;
      end else begin
         // Sample tracking runs regardless of clr.
         prev        <= bus.count;
         phase_vld_q <= legal;
         if (legal) phase_q <= dec;
         lap_q <= 1'b0;
         first <= 1'b0;

         if (bus.clr) begin
            state     <= UNLOCK;
            good      <= 4'd0;
            first     <= 1'b1;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            lap_cnt_q <= '0;
         end else begin
            case (state)
               UNLOCK: begin
                  if (legal) begin
                     state <= ACQ;
                     good  <= 4'd0;
                  end
               end
               ACQ: begin
                  if (!legal) begin
                     state <= UNLOCK;
                  end else if (adv) begin
                     good <= good + 4'd1;
                     if (good + 4'd1 == LOCK_V) begin
                        state    <= LOCK;
                        locked_q <= 1'b1;
                     end
                  end else if (!hold_ok) begin
                     // legal pattern but out of order: restart acquisition
                     good <= 4'd0;
                  end
               end
               LOCK: begin
                  if (good_tr) begin
                     if (lap_tr) begin
                        lap_q     <= 1'b1;
                        lap_cnt_q <= lap_cnt_q + LAP_W'(1);
                     end
                  end else begin
                     state     <= FAULT;
                     locked_q  <= 1'b0;
                     err_q     <= 1'b1;
                     err_cnt_q <= err_cnt_inc;
                  end
               end
               FAULT: begin
                  if (legal) begin
                     state <= ACQ;
                     good  <= 4'd0;
                  end else begin
                     err_cnt_q <= err_cnt_inc;
                  end
               end
               default: state <= UNLOCK;
            endcase
         end
      end
   end

   assign bus.phase     = phase_q;
   assign bus.phase_vld = phase_vld_q;
   assign bus.locked    = locked_q;
   assign bus.err       = err_q;
   assign bus.err_cnt   = err_cnt_q;
   assign bus.lap       = lap_q;
   assign bus.lap_cnt   = lap_cnt_q;
   assign bus.state     = state;

endmodule
